// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// seq_multiplier : unsigned shift-and-add multiplier, one multiplier bit per
//                  clock, built around a single WIDTH-bit ripple fulladder.
// Revision 1.0
// ============================================================================

module fulladder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             y,
   output logic             c,
   output logic [WIDTH-1:0] s
);
   logic [WIDTH:0] w_carry;

   assign w_carry[0] = y;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
   end

   assign c = w_carry[WIDTH];
endmodule

module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);
   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mcand_q;
   // The accumulator's extra top bit is always zero after each shift, so only
   // the low 2*WIDTH bits carry information and are stored.
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   p_q;
   logic                 busy_q;
   logic                 done_q;

   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_cout;

   assign w_addend = acc_q[0] ? mcand_q : '0;

   fulladder #(.WIDTH(WIDTH)) u_add (
      .a (acc_q[2*WIDTH-1:WIDTH]),
      .b (w_addend),
      .y (1'b0),
      .c (w_cout),
      .s (w_sum)
   );

   // Conditional add, then shift right by one.
   assign acc_d = {w_cout, w_sum, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mcand_q <= a;
                  acc_q   <= {{WIDTH{1'b0}}, b};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  p_q     <= acc_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// tb_seq_multiplier : directed and random checks of seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0, start4 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy8, done8, busy4, done4;
   logic [15:0] p8;
   logic [7:0]  p4;
   logic        sel4 = 1'b0;
   logic        busy_s, done_s;
   logic [15:0] p_s;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8)
   );

   seq_multiplier #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .p(p4)
   );

   assign busy_s = sel4 ? busy4 : busy8;
   assign done_s = sel4 ? done4 : done8;
   assign p_s    = sel4 ? {8'h00, p4} : p8;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full operation on the selected instance: accept, wait for done, check.
   task automatic mul(input bit w4, input logic [7:0] av, input logic [7:0] bv);
      logic [15:0] exp_p;
      logic [15:0] prev_p;
      int          w;
      int          lat;
      int          bcnt;
      sel4   = w4;
      w      = w4 ? 4 : 8;
      exp_p  = 16'(av) * 16'(bv);
      #0;
      prev_p = p_s;
      if (w4) begin
         a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1;
      end else begin
         a8 = av; b8 = bv; start8 = 1'b1;
      end
      tick();
      start4 = 1'b0;
      start8 = 1'b0;
      a8 = 8'hxx; b8 = 8'hxx; a4 = 4'hx; b4 = 4'hx;
      check("accept_p_held", p_s, prev_p);
      check("accept_busy", busy_s, 1);
      lat  = 0;
      bcnt = 1;
      while (!done_s && lat < 40) begin
         tick();
         lat++;
         if (busy_s) bcnt++;
      end
      check("latency", lat, w);
      check("product", p_s, exp_p);
      tick();
      check("done_width", done_s, 0);
      check("busy_after", busy_s, 0);
      check("busy_cycles", bcnt, w + 1);
      check("p_hold_idle", p_s, exp_p);
   endtask

   initial begin
      int lat;
      int gap;
      int seen;
      bit hold_ok;

      // Reset state
      repeat (3) tick();
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_p8", p8, 0);
      check("rst_p4", p4, 0);
      rst = 1'b0;
      tick();

      // Directed products
      mul(0, 8'd13, 8'd11);
      mul(0, 8'd255, 8'd255);
      mul(0, 8'd0, 8'd200);
      mul(0, 8'd200, 8'd0);
      mul(0, 8'd1, 8'd255);

      // start held high: ignored during RUN/DONE, re-accepted on first IDLE edge
      sel4 = 1'b0;
      a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
      tick();
      lat = 0;
      while (!done8 && lat < 40) begin tick(); lat++; end
      check("held_latency", lat, 8);
      check("held_p1", p8, 15);
      gap = 0;
      hold_ok = 1'b1;
      do begin
         tick();
         gap++;
         if (p8 !== 16'd15) hold_ok = 1'b0;
      end while (!done8 && gap < 40);
      check("held_gap", gap, 10);
      check("held_p_stable", hold_ok, 1);
      start8 = 1'b0;
      tick();
      check("held_idle_busy", busy8, 0);

      // Reset in the middle of RUN discards the operation
      a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      check("midrun_busy", busy8, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy8, 0);
      check("arst_done", done8, 0);
      check("arst_p", p8, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 0;
      repeat (15) begin
         tick();
         if (done8) seen++;
      end
      check("arst_no_done", seen, 0);
      check("arst_idle_busy", busy8, 0);
      mul(0, 8'd100, 8'd7);

      // WIDTH=4 directed
      mul(1, 8'd15, 8'd15);
      mul(1, 8'd9, 8'd0);

      // Random regression at both widths
      for (int i = 0; i < 1000; i++)
         mul(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 1000; i++)
         mul(1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
